// File: rtl/cf_fft_1024_8_bitrev.sv
// Purpose: reorders bit-reversed FFT output frames into natural order via a ping-pong RAM.
// Latency: N+1 enabled edges from input sample 0 to output sample 0 (1025 for N=1024).
// Backpressure: none; i4 low freezes every register and output, no data is dropped.
module cf_fft_1024_8_bitrev #(
   parameter int LOG2N = 10,
   parameter int WIDTH = 16
) (
   input  logic             clock_c,
   input  logic             i5,
   input  logic             i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic             i4,
   output logic             o1,
   output logic [WIDTH-1:0] o2,
   output logic [WIDTH-1:0] o3,
   output logic             o4
);

   localparam int N = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST = '1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

   state_t           state_q, state_d;
   logic [LOG2N-1:0] wc_q, wc_d;
   logic             wb_q, wb_d;
   logic [LOG2N-1:0] rc_q, rc_d;
   logic             rb_q, rb_d;
   logic             reading_q, reading_d;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr;
   logic             arm;

   // Pipeline between RAM read and the output registers.
   logic [2*WIDTH-1:0] rd_q;
   logic               vld_q;
   logic               sync_q;
   logic               o1_q, o4_q;
   logic [WIDTH-1:0]   o2_q, o3_q;

   logic [2*WIDTH-1:0] mem [0:2*N-1];

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
      return r;
   endfunction

   // Write-side FSM: picks write address, tracks frame position, arms the reader on frame completion.
   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      wb_d    = wb_q;
      wr_en   = 1'b0;
      wr_addr = '0;
      arm     = 1'b0;
      if (i4) begin
         case (state_q)
            S_IDLE: begin
               if (i1) begin
                  wr_en   = 1'b1;
                  wr_addr = '0;
                  wc_d    = {{(LOG2N-1){1'b0}}, 1'b1};
                  state_d = S_FILL;
               end
            end
            default: begin
               wr_en = 1'b1;
               if (i1 && (wc_q != '0)) begin
                  // Resync: restart the partial frame in the same bank; the reader keeps going.
                  wr_addr = '0;
                  wc_d    = {{(LOG2N-1){1'b0}}, 1'b1};
                  state_d = S_FILL;
               end else begin
                  wr_addr = bitrev(wc_q);
                  wc_d    = wc_q + 1'b1;
                  if (wc_q == LAST) begin
                     wb_d    = ~wb_q;
                     arm     = 1'b1;
                     state_d = S_STREAM;
                  end
               end
            end
         endcase
      end
   end

   // Read-side sequencing: sequential addresses; a new arm wins over end-of-frame so frames abut.
   always_comb begin
      rc_d      = rc_q;
      rb_d      = rb_q;
      reading_d = reading_q;
      if (i4 && reading_q) begin
         rc_d = rc_q + 1'b1;
         if (rc_q == LAST) reading_d = 1'b0;
      end
      if (arm) begin
         rc_d      = '0;
         rb_d      = wb_q;
         reading_d = 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge clock_c or posedge i5) begin
      if (i5) begin
         state_q   <= S_IDLE;
         wc_q      <= '0;
         wb_q      <= 1'b0;
         rc_q      <= '0;
         rb_q      <= 1'b0;
         reading_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wc_q      <= wc_d;
         wb_q      <= wb_d;
         rc_q      <= rc_d;
         rb_q      <= rb_d;
         reading_q <= reading_d;
      end
   end

   // Frame RAM with one write and one registered read port; contents are never reset.
   always_ff @(posedge clock_c) begin
      if (wr_en) mem[{wb_q, wr_addr}] <= {i2, i3};
      if (i4 && reading_q) rd_q <= mem[{rb_q, rc_q}];
   end

   // Output stage: flags follow the read issue by one edge, data is captured only for valid reads.
   always_ff @(posedge clock_c or posedge i5) begin
      if (i5) begin
         vld_q  <= 1'b0;
         sync_q <= 1'b0;
         o1_q   <= 1'b0;
         o4_q   <= 1'b0;
         o2_q   <= '0;
         o3_q   <= '0;
      end else if (i4) begin
         vld_q  <= reading_q;
         sync_q <= reading_q && (rc_q == '0);
         o1_q   <= sync_q;
         o4_q   <= vld_q;
         if (vld_q) begin
            o2_q <= rd_q[2*WIDTH-1:WIDTH];
            o3_q <= rd_q[WIDTH-1:0];
         end
      end
   end

   assign o1 = o1_q;
   assign o2 = o2_q;
   assign o3 = o3_q;
   assign o4 = o4_q;

endmodule

// File: tb/tb_cf_fft_1024_8_bitrev.sv
module tb_cf_fft_1024_8_bitrev;

   localparam int LOG2N = 10;
   localparam int N     = 1024;
   localparam int W     = 16;

   logic         clock_c = 1'b0;
   logic         i5;
   logic         i1;
   logic [W-1:0] i2;
   logic [W-1:0] i3;
   logic         i4;
   logic         o1;
   logic [W-1:0] o2;
   logic [W-1:0] o3;
   logic         o4;

   int vectors     = 0;
   int miscompares = 0;
   int en_cnt      = 0;
   int first_edge  = 0;
   int run_len     = 0;
   int max_run     = 0;
   int lat;
   logic [32:0] exp_q[$];
   int          o1_edges[$];

   cf_fft_1024_8_bitrev #(.LOG2N(LOG2N), .WIDTH(W)) dut (
      .clock_c(clock_c), .i5(i5), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
      .o1(o1), .o2(o2), .o3(o3), .o4(o4)
   );

   always #5 clock_c = ~clock_c;

   function automatic logic [9:0] brev(input logic [9:0] a);
      logic [9:0] r;
      for (int b = 0; b < 10; b++) r[b] = a[9-b];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One clock edge with the given inputs, then check outputs 1 time unit later.
   task automatic cyc(input logic s, input logic [W-1:0] re, input logic [W-1:0] im, input logic en);
      logic [2*W+1:0] prev;
      logic [32:0]    e;
      i1 = s; i2 = re; i3 = im; i4 = en;
      prev = {o1, o4, o2, o3};
      @(posedge clock_c); #1;
      if (!en) begin
         chk("hold", {30'd0, o1, o4, o2, o3}, {30'd0, prev});
      end else begin
         en_cnt++;
         if (o4) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         if (o1) o1_edges.push_back(en_cnt);
         if (exp_q.size() == 0) begin
            chk("unexpected_o4", {63'd0, o4}, 64'd0);
         end else if (o4) begin
            e = exp_q.pop_front();
            chk("sample", {31'd0, o1, o2, o3}, {31'd0, e});
         end
      end
   endtask

   task automatic gap(input bit gaps);
      if (gaps) begin
         for (int g = 0; g < 8 && $urandom_range(1) == 0; g++)
            cyc(1'($urandom_range(1)), W'($urandom), W'($urandom), 1'b0);
      end
   endtask

   task automatic frame(input logic [W-1:0] off, input int len, input bit gaps, input bit marks);
      logic [W-1:0] re, im;
      for (int j = 0; j < len; j++) begin
         gap(gaps);
         re = W'(brev(10'(j))) + off;
         im = W'(N - 1) - W'(brev(10'(j)));
         if (marks && j == 1)     re = 16'hAAAA;
         if (marks && j == N - 2) re = 16'h5555;
         cyc(j == 0, re, im, 1'b1);
         if (j == 0) first_edge = en_cnt;
      end
   endtask

   task automatic push_frame(input logic [W-1:0] off, input bit marks);
      logic [W-1:0] re, im;
      for (int k = 0; k < N; k++) begin
         re = W'(k) + off;
         im = W'(N - 1 - k);
         if (marks && k == 512) re = 16'hAAAA;
         if (marks && k == 511) re = 16'h5555;
         exp_q.push_back({k == 0, re, im});
      end
   endtask

   // Exactly enough enabled edges to flush the last armed frame, before the filler frame would emerge.
   task automatic drain(input bit gaps);
      for (int k = 0; k < N + 1; k++) begin
         gap(gaps);
         cyc(1'b0, W'($urandom), W'($urandom), 1'b1);
      end
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      #2 i5 = 1'b1;
      #1;
      chk("reset_outs", {30'd0, o1, o4, o2, o3}, 64'd0);
      exp_q.delete();
      o1_edges.delete();
      run_len = 0;
      max_run = 0;
      @(posedge clock_c); #1;
      i5 = 1'b0;
   endtask

   initial begin
      i5 = 1'b1; i1 = 1'b0; i2 = '0; i3 = '0; i4 = 1'b0;
      repeat (2) @(posedge clock_c);
      #1;
      chk("por_outs", {30'd0, o1, o4, o2, o3}, 64'd0);
      i5 = 1'b0;

      // No sync after reset: output must stay idle.
      for (int k = 0; k < 40; k++) cyc(1'b0, W'($urandom), W'($urandom), 1'b1);
      chk("idle_o4", {63'd0, o4}, 64'd0);

      // Single frame, natural-order ramp out.
      frame(16'd0, N, 1'b0, 1'b0);
      push_frame(16'd0, 1'b0);
      drain(1'b0);
      chk("single_o1_count", 64'(o1_edges.size()), 64'd1);
      lat = (o1_edges.size() > 0) ? o1_edges[0] - first_edge : -1;
      chk("single_latency", 64'(lat), 64'd1025);
      chk("prereset_o4", {63'd0, o4}, 64'd1);
      do_reset();

      // Two frames back to back.
      frame(16'd0, N, 1'b0, 1'b0);
      push_frame(16'd0, 1'b0);
      frame(16'd2048, N, 1'b0, 1'b0);
      push_frame(16'd2048, 1'b0);
      drain(1'b0);
      chk("b2b_o1_count", 64'(o1_edges.size()), 64'd2);
      lat = (o1_edges.size() > 1) ? o1_edges[1] - o1_edges[0] : -1;
      chk("b2b_o1_spacing", 64'(lat), 64'd1024);
      chk("b2b_o4_run", 64'(max_run), 64'd2048);
      do_reset();

      // Single frame with random enable gaps.
      frame(16'd0, N, 1'b1, 1'b0);
      push_frame(16'd0, 1'b0);
      drain(1'b1);
      chk("gaps_o1_count", 64'(o1_edges.size()), 64'd1);
      do_reset();

      // Resync: A complete, B aborted at j=500, C complete.
      frame(16'd0, N, 1'b0, 1'b0);
      push_frame(16'd0, 1'b0);
      frame(16'h4000, 500, 1'b0, 1'b0);
      frame(16'h6000, N, 1'b0, 1'b0);
      chk("resync_gap_o4", {63'd0, o4}, 64'd0);
      push_frame(16'h6000, 1'b0);
      drain(1'b0);
      chk("resync_o1_count", 64'(o1_edges.size()), 64'd2);
      lat = (o1_edges.size() > 1) ? o1_edges[1] - o1_edges[0] : -1;
      chk("resync_o1_spacing", 64'(lat), 64'd1524);
      do_reset();

      // Bit-reversal corners: j=1 -> 512, j=N-2 -> 511.
      frame(16'd0, N, 1'b0, 1'b1);
      push_frame(16'd0, 1'b1);
      drain(1'b0);
      do_reset();

      for (int k = 0; k < 30; k++) cyc(1'b0, W'($urandom), W'($urandom), 1'b1);
      chk("post_reset_idle_o4", {63'd0, o4}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cf_fft_1024_8_bitrev.md
# cf_fft_1024_8_bitrev

Output reorder stage placed directly downstream of the 1024-point streaming FFT core. The FFT core emits one complex sample per enabled cycle in bit-reversed order, with a one-cycle sync pulse on the first sample of each frame. This block buffers each frame in a ping-pong RAM, writing at bit-reversed addresses and reading sequentially. It re-emits the frame in natural order, using the same sync/enable streaming convention as the core.

## Interface

Parameters:
- LOG2N, default 10: log2 of frame length (N = 1024).
- WIDTH, default 16: bits per real/imag component.

Ports:
- clock_c  input  1  single clock; all state updates on rising edge.
- i5  input  1  reset; asynchronous, active-high.
- i1  input  1  input sync; high with sample 0 of an input frame.
- i2  input  WIDTH  input real component.
- i3  input  WIDTH  input imaginary component.
- i4  input  1  clock enable; nothing advances while low.
- o1  output  1  output sync; high with natural-order sample 0.
- o2  output  WIDTH  output real component.
- o3  output  WIDTH  output imaginary component.
- o4  output  1  output valid.

## Operation

- Storage: two banks of N words, each 2*WIDTH bits ({real, imag}). Memory contents are not reset. One synchronous read port; read data is registered into o2/o3.
- Write side:
  - Write counter wc (LOG2N bits) and write-bank select wb.
  - Each accepted sample with arrival index j is written to address bitrev(wc) in bank wb. bitrev is the LOG2N-bit reversal, so bitrev(1)=512 and bitrev(3)=768.
- State machine (advances only on enabled edges, i.e. i4=1):
  - IDLE: samples ignored. On i1=1, the sample is written at addr 0, wc<=1, go to FILL.
  - FILL: write each sample; wc increments. When the sample is written at wc=N-1: wc wraps to 0, wb toggles, the read side is armed on the completed bank, go to STREAM.
  - STREAM: same write behaviour, with frames back to back and wc free-running. i1 at wc=0 is consistent and needs no action.
- Resync: i1=1 while wc!=0, in FILL or STREAM.
  - The partial frame in bank wb is discarded.
  - The current sample is written at addr 0 of the same bank and wc<=1.
  - The read side is unaffected and finishes the previously completed frame.
- Read side:
  - On arm: read counter rc<=0, rb<=completed bank, reading<=1. Address rc is issued on each enabled edge and rc increments.
  - After issuing rc=N-1, reading clears unless re-armed on the same edge. Re-arming takes priority, so back-to-back frames stream with no gap.
  - o4 = registered (reading at issue time). o1 = registered (reading && rc==0).
- Write and read never target the same bank simultaneously, because arm swaps wb.
- Reset (asynchronous, active-high):
  - State IDLE; wc=rc=0; wb=rb=0; reading=0.
  - o1=0, o2=0, o3=0, o4=0.
  - A reset mid-frame discards all buffered data.

## Timing

- All edges referenced here are enabled edges (i4=1). With i4=0, every register and output holds its value.
- Input sample with wc=N-1 is accepted at edge E.
  - Address 0 of the completed bank is issued at E+1.
  - o2/o3 show natural sample 0, with o1=1 and o4=1, after E+2.
  - Sample k appears after E+2+k.
- Latency from the first sample of a frame to its output sample 0 is N+1 enabled edges (1025).
- o1 is high for exactly one enabled-output period per frame.
- Continuous input with no resync gives continuous o4=1 from the first frame onward.
- After a resync, o4 falls after the old frame's last sample. It stays low until the new frame completes.
- i1 in IDLE on the same edge as any other event: i1 handling takes precedence.

## Test plan

- Reset: assert i5 asynchronously mid-stream, with no clock edge needed. Required: o1=o4=0 and o2=o3=0 immediately. After release with no i1, o4 stays 0 indefinitely.
- Single frame: i4=1, i1 pulse, sample j carries real=bitrev(j), imag=N-1-bitrev(j). Required: o2 = 0,1,…,1023 and o3 = 1023…0. o1=1 only with o2=0, exactly 1025 edges after the first input.
- Back-to-back frames: two frames, the second with real offset +2048 (mod 2^16). Required: o4 high for 2048 consecutive cycles and second o1 exactly 1024 cycles after the first.
- Enable gaps: repeat the single-frame test with i4 pseudo-random (~50%). Required: an identical output sequence. Outputs hold while i4=0, with no duplicates or drops.
- Resync: full frame A, then frame B aborted at j=500 by i1, then complete frame C. Required: all of A output in order, followed by o4 low. Next o1 carries C sample 0; no B data appears.
- Bit-reversal corners: inputs at j=1 and j=N-2 marked with distinct values. Required: they appear at natural index 512 and 511 respectively.
